cpu_reset_seq: RTL
==================

# cpu_reset_seq

Reset sequencer and supervisor for the CPU clock PLL. Runs in the 100 MHz system clock domain. Drives the PLL reset, waits for PLL lock with timeout and bounded retry, and requires lock to be stable before it releases CPU reset. It also re-sequences the PLL on loss of lock and provides a software-requested CPU-only reset. It sits between the board reset logic, the CPU clock generator, and the CPU core's reset synchronizer.

## Interface
Parameters:
- PLL_RESET_CYCLES, 8, number of cycles pll_reset_o is held per attempt; must be ≥3
- LOCK_TIMEOUT, 4096, number of cycles allowed in WAIT_LOCK before the attempt fails
- STABLE_CYCLES, 64, number of consecutive locked cycles required before CPU reset is released
- MAX_RETRIES, 3, number of failed attempts tolerated; attempt MAX_RETRIES+1 failing enters FAULT
- SOFT_RESET_CYCLES, 16, length of a CPU-only reset pulse

Ports:
- sys_clk_i  in  1  100 MHz system clock; the only clock
- reset_i  in  1  synchronous, active-high reset
- pll_locked_async_i  in  1  PLL LOCKED, asynchronous to sys_clk_i
- soft_reset_req_i  in  1  single-cycle request for a CPU-only reset (sys_clk domain)
- pll_reset_o  out  1  PLL RST
- cpu_reset_o  out  1  CPU reset request (the CPU clock domain resynchronizes it)
- ready_o  out  1  CPU clock valid and CPU out of reset
- fault_o  out  1  PLL failed to lock after all retries
- retry_count_o  out  $clog2(MAX_RETRIES+1)  number of failed attempts since the last RUN

## Operation
- Two-flop synchronizer on pll_locked_async_i produces lock_s. Only lock_s is used by the rest of the block.
- All outputs are registered and are updated on the same edge as the state register.
- One counter, cnt, is shared by the states and is cleared on every state transition.
- States and outputs (pll_reset_o, cpu_reset_o, ready_o, fault_o):
  - PLL_RESET (1,1,0,0): after cnt==PLL_RESET_CYCLES-1 → WAIT_LOCK.
  - WAIT_LOCK (0,1,0,0):
    - lock_s=1 → STABLE.
    - Otherwise, at cnt==LOCK_TIMEOUT-1 the attempt fails.
  - STABLE (0,1,0,0):
    - lock_s=0 → the attempt fails.
    - At cnt==STABLE_CYCLES-1 with lock_s=1 → RUN, and retry_count is cleared.
  - RUN (0,0,1,0):
    - lock_s=0 → PLL_RESET. This is not counted as a failure.
    - soft_reset_req_i=1 → CPU_RESET.
  - CPU_RESET (0,1,0,0):
    - lock_s=0 → PLL_RESET. Loss of lock takes priority.
    - At cnt==SOFT_RESET_CYCLES-1 → RUN.
  - FAULT (1,1,0,1): terminal; only reset_i exits.
- Attempt failure:
  - If retry_count==MAX_RETRIES → FAULT.
  - Otherwise retry_count increments and the state goes to PLL_RESET.
- soft_reset_req_i is ignored in every state other than RUN. It is not queued.
- reset_i, from any state and mid-operation, on the next edge sets:
  - state=PLL_RESET, cnt=0, retry_count=0
  - both synchronizer flops = 0
  - outputs: pll_reset_o=1, cpu_reset_o=1, ready_o=0, fault_o=0
- While reset_i is held, cnt stays at 0. The first edge with reset_i=0 counts as PLL_RESET cycle 0.
- Width rules:
  - cnt is sized for the maximum of the count parameters.
  - retry_count saturates at MAX_RETRIES; it never wraps.

## Timing
- Synchronizer latency is 2 edges. A lock change at the input is visible to the FSM on the 2nd edge after it arrives.
- One attempt occupies PLL_RESET_CYCLES cycles in PLL_RESET plus up to LOCK_TIMEOUT cycles in WAIT_LOCK.
- Release of CPU reset:
  - lock_s rises in WAIT_LOCK at edge E.
  - STABLE is entered at E+1.
  - cpu_reset_o falls and ready_o rises at E+1+STABLE_CYCLES.
- Loss of lock in RUN:
  - lock_s falls at edge E.
  - At E+1: cpu_reset_o=1, ready_o=0, pll_reset_o=1.
- A PLL_RESET_CYCLES value of at least 3 guarantees that lock_s reflects the PLL's reset-driven deassertion before WAIT_LOCK samples it.
- Simultaneous soft_reset_req_i and lock_s=0 in RUN → PLL_RESET.

## Test plan
Parameters for all scenarios: PLL_RESET_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2, SOFT_RESET_CYCLES=4.
- Nominal bring-up:
  - Stimulus: release reset_i; raise lock 10 cycles later.
  - Required: pll_reset_o high for exactly 4 cycles. cpu_reset_o falls and ready_o rises exactly 10 edges after the lock input is first sampled. retry_count_o=0.
- Never lock:
  - Stimulus: lock held at 0.
  - Required: retry_count_o steps 1 then 2. fault_o=1 and pll_reset_o=1 at edge 108 after reset release, and both stay high. ready_o is never asserted.
- Lock glitch in STABLE:
  - Stimulus: lock drops for 1 cycle at STABLE cnt=5.
  - Required: returns to PLL_RESET, retry_count_o=1. After a good attempt, RUN is reached and retry_count_o=0.
- Loss of lock in RUN:
  - Stimulus: in RUN, drop lock.
  - Required: at 3 edges after the drop, cpu_reset_o=1 and ready_o=0, and the full sequence reruns. retry_count_o stays 0.
- Soft reset:
  - Stimulus: 1-cycle soft_reset_req_i in RUN.
  - Required: cpu_reset_o high for exactly 4 cycles and pll_reset_o stays 0.
  - Stimulus: the same request pulsed in WAIT_LOCK.
  - Required: no effect.
- Reset mid-operation:
  - Stimulus: assert reset_i in CPU_RESET and again in FAULT.
  - Required: on the next edge, outputs are (1,1,0,0) and retry_count_o=0. Bring-up then follows the nominal timing.

Source files
------------

// File: rtl/cpu_reset_seq.sv
// PLL reset sequencer and CPU reset supervisor for the CPU clock domain.
// Handles PLL lock timeout with bounded retry, lock-stability qualification, and a CPU-only soft reset.
module cpu_reset_seq #(
  parameter int PLL_RESET_CYCLES  = 8,
  parameter int LOCK_TIMEOUT      = 4096,
  parameter int STABLE_CYCLES     = 64,
  parameter int MAX_RETRIES       = 3,
  parameter int SOFT_RESET_CYCLES = 16
) (
  input  logic                               sys_clk_i,
  input  logic                               reset_i,
  input  logic                               pll_locked_async_i,
  input  logic                               soft_reset_req_i,
  output logic                               pll_reset_o,
  output logic                               cpu_reset_o,
  output logic                               ready_o,
  output logic                               fault_o,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count_o
);

  localparam int RC_W    = $clog2(MAX_RETRIES + 1);
  localparam int MAX_AB  = (PLL_RESET_CYCLES > LOCK_TIMEOUT) ? PLL_RESET_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CD  = (STABLE_CYCLES > SOFT_RESET_CYCLES) ? STABLE_CYCLES : SOFT_RESET_CYCLES;
  localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] PLL_LAST     = CNT_W'(PLL_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST    = CNT_W'(SOFT_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT      = {CNT_W{1'b1}};
  localparam logic [RC_W-1:0]  RC_MAX       = RC_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_PLL_RESET = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_CPU_RESET = 3'd4,
    ST_FAULT     = 3'd5
  } state_e;

  logic             sync1_r;
  logic             sync2_r;
  logic             lock_s;
  state_e           state_r;
  state_e           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [RC_W-1:0]  retry_r;
  logic [RC_W-1:0]  retry_nxt_s;
  logic             fail_s;
  logic             pll_reset_r;
  logic             cpu_reset_r;
  logic             ready_r;
  logic             fault_r;
  logic [3:0]       outs_nxt_s;

  assign lock_s        = sync2_r;
  assign pll_reset_o   = pll_reset_r;
  assign cpu_reset_o   = cpu_reset_r;
  assign ready_o       = ready_r;
  assign fault_o       = fault_r;
  assign retry_count_o = retry_r;

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge sys_clk_i) begin
    if (reset_i) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= pll_locked_async_i;
      sync2_r <= sync1_r;
    end
  end

  // Next-state, retry bookkeeping and output decode of the next state.
  always_comb begin
    state_nxt_s = state_r;
    retry_nxt_s = retry_r;
    fail_s      = 1'b0;
    outs_nxt_s  = 4'b1100;
    case (state_r)
      ST_PLL_RESET: begin
        if (cnt_r == PLL_LAST) state_nxt_s = ST_WAIT_LOCK;
        else                   state_nxt_s = ST_PLL_RESET;
      end
      ST_WAIT_LOCK: begin
        if (lock_s)                     state_nxt_s = ST_STABLE;
        else if (cnt_r == TIMEOUT_LAST) fail_s = 1'b1;
        else                            state_nxt_s = ST_WAIT_LOCK;
      end
      ST_STABLE: begin
        if (!lock_s) begin
          fail_s = 1'b1;
        end else if (cnt_r == STABLE_LAST) begin
          state_nxt_s = ST_RUN;
          retry_nxt_s = {RC_W{1'b0}};
        end else begin
          state_nxt_s = ST_STABLE;
        end
      end
      // Loss of lock outranks a simultaneous soft reset request.
      ST_RUN: begin
        if (!lock_s)               state_nxt_s = ST_PLL_RESET;
        else if (soft_reset_req_i) state_nxt_s = ST_CPU_RESET;
        else                       state_nxt_s = ST_RUN;
      end
      ST_CPU_RESET: begin
        if (!lock_s)                 state_nxt_s = ST_PLL_RESET;
        else if (cnt_r == SOFT_LAST) state_nxt_s = ST_RUN;
        else                         state_nxt_s = ST_CPU_RESET;
      end
      ST_FAULT: begin
        state_nxt_s = ST_FAULT;
      end
      default: begin
        state_nxt_s = ST_PLL_RESET;
      end
    endcase

    if (fail_s) begin
      if (retry_r >= RC_MAX) begin
        state_nxt_s = ST_FAULT;
      end else begin
        retry_nxt_s = retry_r + RC_W'(1);
        state_nxt_s = ST_PLL_RESET;
      end
    end else begin
      retry_nxt_s = retry_nxt_s;
    end

    // Output order: {pll_reset, cpu_reset, ready, fault}.
    case (state_nxt_s)
      ST_PLL_RESET: outs_nxt_s = 4'b1100;
      ST_WAIT_LOCK: outs_nxt_s = 4'b0100;
      ST_STABLE:    outs_nxt_s = 4'b0100;
      ST_RUN:       outs_nxt_s = 4'b0010;
      ST_CPU_RESET: outs_nxt_s = 4'b0100;
      ST_FAULT:     outs_nxt_s = 4'b1101;
      default:      outs_nxt_s = 4'b1100;
    endcase
  end

  // State, shared counter, retry count and registered outputs.
  always_ff @(posedge sys_clk_i) begin
    if (reset_i) begin
      state_r     <= ST_PLL_RESET;
      cnt_r       <= {CNT_W{1'b0}};
      retry_r     <= {RC_W{1'b0}};
      pll_reset_r <= 1'b1;
      cpu_reset_r <= 1'b1;
      ready_r     <= 1'b0;
      fault_r     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      retry_r <= retry_nxt_s;
      // Counter holds at all-ones so it never wraps in RUN or FAULT.
      if (state_nxt_s != state_r) cnt_r <= {CNT_W{1'b0}};
      else if (cnt_r != CNT_SAT)  cnt_r <= cnt_r + CNT_W'(1);
      else                        cnt_r <= cnt_r;
      {pll_reset_r, cpu_reset_r, ready_r, fault_r} <= outs_nxt_s;
    end
  end

endmodule
